// File: rtl/regfile_bank.sv
// Integer register file with two combinational read ports, one write port,
// optional same-cycle write forwarding and hardwired x0. After every reset a
// sweep writes zero into each register before the bank reports ready. A
// per-register busy scoreboard tracks in-flight producers between decode and
// writeback.
module regfile_bank #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ready,
  input  logic            we,
  input  logic [AW-1:0]   rd_index,
  input  logic [XLEN-1:0] rd_data,
  input  logic [AW-1:0]   rs1_index,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_index,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_set_index,
  input  logic            sb_flush
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   rf_q [NREGS];

  logic              run;
  logic              wr_ok;
  logic              set_ok;

  // An index names a real, writable register: in range and not the hardwired x0.
  function automatic logic idx_legal(input logic [AW-1:0] idx);
    logic in_range;
    logic is_zero;
    in_range = (32'(idx) < NREGS);
    is_zero  = (ZERO_REG != 0) && (idx == '0);
    return in_range && !is_zero;
  endfunction

  assign run    = (state_q == StRun);
  assign ready  = run;
  assign wr_ok  = run && we && idx_legal(rd_index);
  assign set_ok = run && sb_set && idx_legal(sb_set_index);

  // Sweep sequencing: INIT walks cnt over every register, then RUN until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = StRun;
      end
    end
  end

  // Scoreboard next state: flush beats set, set beats a completing write.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (sb_flush) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < NREGS; i++) begin
          if (set_ok && (sb_set_index == AW'(i))) begin
            busy_d[i] = 1'b1;
          end else if (wr_ok && (rd_index == AW'(i))) begin
            busy_d[i] = 1'b0;
          end
        end
      end
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Register array: the reset edge itself leaves contents alone; the sweep clears them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == StInit) begin
        rf_q[cnt_q] <= '0;
      end else if (wr_ok) begin
        rf_q[rd_index] <= rd_data;
      end
    end
  end

  // Read port 1: zero for unreadable indices or during INIT, forwarding when enabled.
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (run && idx_legal(rs1_index)) begin
      if ((BYPASS != 0) && wr_ok && (rd_index == rs1_index)) begin
        rs1_data = rd_data;
      end else begin
        rs1_data = rf_q[rs1_index];
        rs1_busy = busy_q[rs1_index];
      end
    end
  end

  // Read port 2: identical behaviour to port 1.
  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (run && idx_legal(rs2_index)) begin
      if ((BYPASS != 0) && wr_ok && (rd_index == rs2_index)) begin
        rs2_data = rd_data;
      end else begin
        rs2_data = rf_q[rs2_index];
        rs2_busy = busy_q[rs2_index];
      end
    end
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank. Three instances share one stimulus stream:
// the default configuration, a BYPASS=0 variant and an NREGS=24 variant.
module tb_regfile_bank;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] rd_index = '0;
  logic [31:0]   rd_data = '0;
  logic [AW-1:0] rs1_index = '0;
  logic [AW-1:0] rs2_index = '0;
  logic          sb_set = 1'b0;
  logic [AW-1:0] sb_set_index = '0;
  logic          sb_flush = 1'b0;

  logic          m_ready, m_b1, m_b2;
  logic [31:0]   m_d1, m_d2;
  logic          n_ready, n_b1, n_b2;
  logic [31:0]   n_d1, n_d2;
  logic          s_ready, s_b1, s_b2;
  logic [31:0]   s_d1, s_d2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_bank u_main (
    .clk(clk), .rst_n(rst_n), .ready(m_ready), .we(we), .rd_index(rd_index),
    .rd_data(rd_data), .rs1_index(rs1_index), .rs1_data(m_d1), .rs1_busy(m_b1),
    .rs2_index(rs2_index), .rs2_data(m_d2), .rs2_busy(m_b2), .sb_set(sb_set),
    .sb_set_index(sb_set_index), .sb_flush(sb_flush)
  );

  regfile_bank #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .ready(n_ready), .we(we), .rd_index(rd_index),
    .rd_data(rd_data), .rs1_index(rs1_index), .rs1_data(n_d1), .rs1_busy(n_b1),
    .rs2_index(rs2_index), .rs2_data(n_d2), .rs2_busy(n_b2), .sb_set(sb_set),
    .sb_set_index(sb_set_index), .sb_flush(sb_flush)
  );

  regfile_bank #(.NREGS(24)) u_d24 (
    .clk(clk), .rst_n(rst_n), .ready(s_ready), .we(we), .rd_index(rd_index),
    .rd_data(rd_data), .rs1_index(rs1_index), .rs1_data(s_d1), .rs1_busy(s_b1),
    .rs2_index(rs2_index), .rs2_data(s_d2), .rs2_busy(s_b2), .sb_set(sb_set),
    .sb_set_index(sb_set_index), .sb_flush(sb_flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        set;
    logic [4:0]  si;
    logic        flush;
    logic [31:0] e1;   // main rs1_data
    logic        b1;   // main rs1_busy
    logic [31:0] e2;   // main rs2_data
    logic        b2;   // main rs2_busy
    logic [31:0] enb;  // BYPASS=0 rs1_data
    logic [31:0] e24;  // NREGS=24 rs1_data
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [4:0] rd, input logic [31:0] wd,
                              input logic [4:0] r1, input logic [4:0] r2, input logic set,
                              input logic [4:0] si, input logic fl, input logic [31:0] e1,
                              input logic b1, input logic [31:0] e2, input logic b2,
                              input logic [31:0] enb, input logic [31:0] e24);
    vec_t v;
    v.we = w; v.rd = rd; v.wd = wd; v.r1 = r1; v.r2 = r2; v.set = set; v.si = si;
    v.flush = fl; v.e1 = e1; v.b1 = b1; v.e2 = e2; v.b2 = b2; v.enb = enb; v.e24 = e24;
    return v;
  endfunction

  vec_t vt[23];
  int   rdy_m, rdy_n, rdy_s;

  initial begin
    //          we rd  wdata         r1  r2  set si fl  e1            b1 e2            b2 enb           e24
    vt[0]  = mk(1, 7,  32'h12345678, 7,  0,  0, 0, 0, 32'h12345678, 0, 32'h0,        0, 32'h0,        32'h12345678);
    vt[1]  = mk(1, 0,  32'hFFFFFFFF, 7,  0,  0, 0, 0, 32'h12345678, 0, 32'h0,        0, 32'h12345678, 32'h12345678);
    vt[2]  = mk(0, 0,  32'h0,        7,  0,  0, 0, 0, 32'h12345678, 0, 32'h0,        0, 32'h12345678, 32'h12345678);
    vt[3]  = mk(0, 0,  32'h0,        3,  3,  1, 3, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    vt[4]  = mk(0, 0,  32'h0,        3,  3,  0, 0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        32'h0);
    vt[5]  = mk(1, 3,  32'hA5A5A5A5, 3,  7,  0, 0, 0, 32'hA5A5A5A5, 0, 32'h12345678, 0, 32'h0,        32'hA5A5A5A5);
    vt[6]  = mk(0, 0,  32'h0,        3,  3,  0, 0, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    vt[7]  = mk(0, 0,  32'h0,        9,  9,  1, 9, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    vt[8]  = mk(0, 0,  32'h0,        3,  9,  0, 0, 0, 32'hA5A5A5A5, 0, 32'h0,        1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    vt[9]  = mk(1, 9,  32'h99,       3,  9,  0, 0, 0, 32'hA5A5A5A5, 0, 32'h99,       0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    vt[10] = mk(1, 9,  32'h100,      9,  9,  1, 9, 0, 32'h100,      0, 32'h100,      0, 32'h99,       32'h100);
    vt[11] = mk(0, 0,  32'h0,        9,  9,  0, 0, 0, 32'h100,      1, 32'h100,      1, 32'h100,      32'h100);
    vt[12] = mk(0, 0,  32'h0,        0,  9,  1, 0, 0, 32'h0,        0, 32'h100,      1, 32'h0,        32'h0);
    vt[13] = mk(0, 0,  32'h0,        0,  9,  1, 1, 0, 32'h0,        0, 32'h100,      1, 32'h0,        32'h0);
    vt[14] = mk(0, 0,  32'h0,        1,  2,  1, 2, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    vt[15] = mk(0, 0,  32'h0,        2,  31, 1, 31, 0, 32'h0,       1, 32'h0,        0, 32'h0,        32'h0);
    vt[16] = mk(0, 0,  32'h0,        31, 1,  1, 4, 1, 32'h0,        1, 32'h0,        1, 32'h0,        32'h0);
    vt[17] = mk(0, 0,  32'h0,        4,  9,  0, 0, 0, 32'h0,        0, 32'h100,      0, 32'h0,        32'h0);
    vt[18] = mk(0, 0,  32'h0,        31, 2,  0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    vt[19] = mk(1, 31, 32'hCAFEF00D, 31, 31, 0, 0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 32'h0,        32'h0);
    vt[20] = mk(0, 0,  32'h0,        31, 30, 0, 0, 0, 32'hCAFEF00D, 0, 32'h0,        0, 32'hCAFEF00D, 32'h0);
    vt[21] = mk(1, 30, 32'h55,       30, 7,  0, 0, 0, 32'h55,       0, 32'h12345678, 0, 32'h0,        32'h0);
    vt[22] = mk(0, 0,  32'h0,        30, 31, 0, 0, 0, 32'h55,       0, 32'hCAFEF00D, 0, 32'h55,       32'h0);

    // Reset held two edges; nothing ready, reads forced to zero.
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(m_ready), 32'h0);
    chk("reset rs1_data", m_d1, 32'h0);

    // Release with a write attempt pending; restart mid-sweep at cycle 10.
    @(negedge clk);
    rst_n = 1'b1; we = 1'b1; rd_index = 5; rd_data = 32'hDEADBEEF; rs1_index = 5;
    repeat (10) @(posedge clk);
    #1;
    chk("sweep10 ready", 32'(m_ready), 32'h0);
    chk("sweep10 rs1_data", m_d1, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    rdy_m = 0; rdy_n = 0; rdy_s = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (m_ready && rdy_m == 0) begin
        rdy_m = k;
        we = 1'b0;
      end
      if (n_ready && rdy_n == 0) rdy_n = k;
      if (s_ready && rdy_s == 0) rdy_s = k;
    end
    chk("ready edges main", 32'(rdy_m), 32'd32);
    chk("ready edges nobyp", 32'(rdy_n), 32'd32);
    chk("ready edges d24", 32'(rdy_s), 32'd24);
    chk("r5 after sweep", m_d1, 32'h0);
    chk("r5 busy after sweep", 32'(m_b1), 32'h0);

    // Table of single-cycle vectors, checked before the edge that applies them.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      we = vt[i].we; rd_index = vt[i].rd; rd_data = vt[i].wd;
      rs1_index = vt[i].r1; rs2_index = vt[i].r2;
      sb_set = vt[i].set; sb_set_index = vt[i].si; sb_flush = vt[i].flush;
      #1;
      chk($sformatf("v%0d rs1_data", i), m_d1, vt[i].e1);
      chk($sformatf("v%0d rs1_busy", i), 32'(m_b1), 32'(vt[i].b1));
      chk($sformatf("v%0d rs2_data", i), m_d2, vt[i].e2);
      chk($sformatf("v%0d rs2_busy", i), 32'(m_b2), 32'(vt[i].b2));
      chk($sformatf("v%0d nobyp rs1_data", i), n_d1, vt[i].enb);
      chk($sformatf("v%0d d24 rs1_data", i), s_d1, vt[i].e24);
    end

    // Reset from RUN: busy and contents cleared by the new sweep.
    @(negedge clk);
    we = 1'b0; sb_flush = 1'b0; sb_set = 1'b1; sb_set_index = 9; rs1_index = 9;
    @(negedge clk);
    sb_set = 1'b0;
    #1;
    chk("run busy r9", 32'(m_b1), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rerun ready", 32'(m_ready), 32'h0);
    chk("rerun rs1_busy", 32'(m_b1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    chk("rerun ready after sweep", 32'(m_ready), 32'h1);
    chk("rerun r9 data", m_d1, 32'h0);
    chk("rerun r9 busy", 32'(m_b1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
